// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package pipe_ctrl_pkg;

    // Stage indices into the stall/flush vectors (stages after fetch)
    localparam int unsigned STG_ID  = 0;
    localparam int unsigned STG_EX  = 1;
    localparam int unsigned STG_MEM = 2;
    localparam int unsigned STG_WB  = 3;

    // ARM-style condition codes carried in a conditional branch
    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE
    } cond_e;

    // Memory wait state machine
    typedef enum logic {
        IDLE     = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_e;

    // Fetch address select
    localparam logic [1:0] ADDR_PC2 = 2'b00;
    localparam logic [1:0] ADDR_TGT = 2'b01;

    // Encoding loaded into a stage register as a bubble
    localparam logic [15:0] NOP_INSTR = 16'hBF00;

endpackage

// File: rtl/pipe_hazard_ctrl_cond_eval.sv
// Evaluates a branch condition code against the {N,Z,C,V} flags.
module cond_eval
    import pipe_ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] apsr,
    output logic       taken
);

    logic n, z, c, v;

    assign {n, z, c, v} = apsr;

    // Condition lookup; reserved code 1111 is never taken
    always_comb begin
        taken = 1'b0;
        case (cond_e'(cond))
            COND_EQ: taken = z;
            COND_NE: taken = ~z;
            COND_CS: taken = c;
            COND_CC: taken = ~c;
            COND_MI: taken = n;
            COND_PL: taken = ~n;
            COND_VS: taken = v;
            COND_VC: taken = ~v;
            COND_HI: taken = c & ~z;
            COND_LS: taken = ~c | z;
            COND_GE: taken = (n == v);
            COND_LT: taken = (n != v);
            COND_GT: taken = ~z & (n == v);
            COND_LE: taken = z | (n != v);
            COND_AL: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: tracks the EX instruction, resolves branches,
// sequences multi-cycle memory waits and detects load-use hazards, merging
// them by priority into per-stage stall and flush vectors.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned NUM_STAGES = 4,
    parameter int unsigned IR_W       = 16,
    parameter int unsigned MEM_CNT_W  = 4,
    parameter int unsigned REG_AW     = 4
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IR_W-1:0]       i_ir_id,
    input  logic                  i_ir_valid,
    input  logic [3:0]            i_apsr,
    input  logic                  i_mem_start,
    input  logic [MEM_CNT_W-1:0]  i_mem_cycles,
    input  logic                  i_ex_load,
    input  logic [REG_AW-1:0]     i_ex_rd,
    input  logic [REG_AW-1:0]     i_id_rs_a,
    input  logic                  i_id_rs_a_en,
    input  logic [REG_AW-1:0]     i_id_rs_b,
    input  logic                  i_id_rs_b_en,
    output logic [NUM_STAGES-1:0] o_stall,
    output logic [NUM_STAGES-1:0] o_flush,
    output logic [1:0]            o_addr_mode,
    output logic                  o_branch_taken,
    output logic                  o_busy
);

    mem_state_e           state, state_nxt;
    logic [MEM_CNT_W-1:0] cnt, cnt_nxt;
    logic [IR_W-1:0]      ir_ex, ir_ex_nxt;
    logic                 cond_taken;
    logic                 br_cond;
    logic                 br_uncond;
    logic                 br_taken;
    logic                 load_use;
    logic                 mem_wait;
    logic                 unused_ir;

    cond_eval u_cond_eval (
        .cond  (ir_ex[11:8]),
        .apsr  (i_apsr),
        .taken (cond_taken)
    );

    // Conditional branch excludes the 1110/1111 encodings (UDF/SVC space)
    assign br_cond   = (ir_ex[15:12] == 4'b1101) && (ir_ex[11:9] != 3'b111);
    assign br_uncond = (ir_ex[15:11] == 5'b11100);
    assign br_taken  = (br_cond && cond_taken) || br_uncond;
    assign mem_wait  = (state == MEM_WAIT);
    assign unused_ir = ^ir_ex;

    assign load_use = i_ex_load &&
                      ((i_id_rs_a_en && (i_id_rs_a == i_ex_rd)) ||
                       (i_id_rs_b_en && (i_id_rs_b == i_ex_rd)));

    assign o_busy = mem_wait;

    // Priority merge: memory wait, then taken branch, then load-use
    always_comb begin
        o_stall        = '0;
        o_flush        = '0;
        o_addr_mode    = ADDR_PC2;
        o_branch_taken = 1'b0;
        if (mem_wait) begin
            o_stall[STG_MEM:STG_ID] = '1;
            o_flush[STG_WB]         = 1'b1;
        end else if (br_taken) begin
            o_branch_taken  = 1'b1;
            o_addr_mode     = ADDR_TGT;
            o_flush[STG_ID] = 1'b1;
            o_flush[STG_EX] = 1'b1;
        end else if (load_use) begin
            o_stall[STG_ID] = 1'b1;
            o_flush[STG_EX] = 1'b1;
        end
    end

    // Memory wait sequencing; a start during MEM_WAIT is ignored
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (i_mem_start && (i_mem_cycles >= MEM_CNT_W'(2))) begin
                    cnt_nxt   = i_mem_cycles - MEM_CNT_W'(1);
                    state_nxt = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                cnt_nxt = cnt - MEM_CNT_W'(1);
                if (cnt == MEM_CNT_W'(1)) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // EX instruction tracking: hold on stall, bubble on flush or invalid ID
    always_comb begin
        ir_ex_nxt = ir_ex;
        if (!o_stall[STG_EX]) begin
            if (o_flush[STG_EX] || o_flush[STG_ID] || !i_ir_valid) begin
                ir_ex_nxt = IR_W'(NOP_INSTR);
            end else begin
                ir_ex_nxt = i_ir_id;
            end
        end
    end

    // State, counter and EX register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            ir_ex <= IR_W'(NOP_INSTR);
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            ir_ex <= ir_ex_nxt;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: table vectors, a condition
// sweep against a reference model, and hand sequences for memory waits,
// branches held during a wait and asynchronous reset.
module tb_pipe_hazard_ctrl;

    localparam logic [15:0] NOP = 16'hBF00;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] i_ir_id;
    logic        i_ir_valid;
    logic [3:0]  i_apsr;
    logic        i_mem_start;
    logic [3:0]  i_mem_cycles;
    logic        i_ex_load;
    logic [3:0]  i_ex_rd;
    logic [3:0]  i_id_rs_a;
    logic        i_id_rs_a_en;
    logic [3:0]  i_id_rs_b;
    logic        i_id_rs_b_en;
    logic [3:0]  o_stall;
    logic [3:0]  o_flush;
    logic [1:0]  o_addr_mode;
    logic        o_branch_taken;
    logic        o_busy;

    int errors = 0;
    int checks = 0;

    pipe_hazard_ctrl #(
        .NUM_STAGES (4),
        .IR_W       (16),
        .MEM_CNT_W  (4),
        .REG_AW     (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_ir_id        (i_ir_id),
        .i_ir_valid     (i_ir_valid),
        .i_apsr         (i_apsr),
        .i_mem_start    (i_mem_start),
        .i_mem_cycles   (i_mem_cycles),
        .i_ex_load      (i_ex_load),
        .i_ex_rd        (i_ex_rd),
        .i_id_rs_a      (i_id_rs_a),
        .i_id_rs_a_en   (i_id_rs_a_en),
        .i_id_rs_b      (i_id_rs_b),
        .i_id_rs_b_en   (i_id_rs_b_en),
        .o_stall        (o_stall),
        .o_flush        (o_flush),
        .o_addr_mode    (o_addr_mode),
        .o_branch_taken (o_branch_taken),
        .o_busy         (o_busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] stall;
        logic [3:0] flush;
        logic [1:0] mode;
        logic       taken;
        logic       busy;
    } exp_t;

    typedef struct packed {
        logic [15:0] ir;
        logic [3:0]  apsr;
        logic        ms;
        logic [3:0]  mc;
        logic        ld;
        logic [3:0]  rd;
        logic [3:0]  ra;
        logic        rae;
        logic [3:0]  rb;
        logic        rbe;
        exp_t        exp;
    } vec_t;

    exp_t sb_q[$];

    function automatic exp_t mk_exp(logic [3:0] s, logic [3:0] f, logic [1:0] m, logic t, logic b);
        exp_t e;
        e.stall = s;
        e.flush = f;
        e.mode  = m;
        e.taken = t;
        e.busy  = b;
        return e;
    endfunction

    function automatic vec_t mkv(logic [15:0] ir, logic [3:0] apsr, logic ms, logic [3:0] mc,
                                 logic ld, logic [3:0] rd, logic [3:0] ra, logic rae,
                                 logic [3:0] rb, logic rbe, exp_t e);
        vec_t v;
        v.ir = ir; v.apsr = apsr; v.ms = ms; v.mc = mc; v.ld = ld; v.rd = rd;
        v.ra = ra; v.rae = rae; v.rb = rb; v.rbe = rbe; v.exp = e;
        return v;
    endfunction

    // Reference branch model using the ARM pairwise encoding (odd code inverts)
    function automatic logic ref_taken(logic [15:0] ir, logic [3:0] f);
        logic       n, z, c, v, base;
        logic [3:0] cc;
        {n, z, c, v} = f;
        cc = ir[11:8];
        if (ir[15:11] == 5'b11100) return 1'b1;
        if (ir[15:12] != 4'hD) return 1'b0;
        case (cc[3:1])
            3'd0:    base = z;
            3'd1:    base = c;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = c & ~z;
            3'd5:    base = (n == v);
            3'd6:    base = ~z & (n == v);
            default: return 1'b0;
        endcase
        return base ^ cc[0];
    endfunction

    task automatic quiet();
        i_ir_id = 16'h0000; i_ir_valid = 1'b1; i_apsr = 4'h0;
        i_mem_start = 1'b0; i_mem_cycles = 4'h0;
        i_ex_load = 1'b0; i_ex_rd = 4'h0;
        i_id_rs_a = 4'h0; i_id_rs_a_en = 1'b0;
        i_id_rs_b = 4'h0; i_id_rs_b_en = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic compare(string name);
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty", name);
            return;
        end
        e = sb_q.pop_front();
        if (o_stall !== e.stall || o_flush !== e.flush || o_addr_mode !== e.mode ||
            o_branch_taken !== e.taken || o_busy !== e.busy) begin
            errors++;
            $display("FAIL %s: got stall=%b flush=%b mode=%b taken=%b busy=%b want stall=%b flush=%b mode=%b taken=%b busy=%b",
                     name, o_stall, o_flush, o_addr_mode, o_branch_taken, o_busy,
                     e.stall, e.flush, e.mode, e.taken, e.busy);
        end
    endtask

    task automatic sample(string name);
        @(negedge clk);
        compare(name);
    endtask

    task automatic check_ir_ex(string name);
        checks++;
        if (dut.ir_ex !== NOP) begin
            errors++;
            $display("FAIL %s: got ir_ex=%h want %h", name, dut.ir_ex, NOP);
        end
    endtask

    // Bring ir into EX over two edges, then apply hazard inputs and check
    task automatic run_vec(vec_t v, string name);
        quiet();
        i_ir_id = NOP;
        tick();
        i_ir_id = v.ir;
        tick();
        i_ir_id = 16'h0000;
        i_apsr = v.apsr; i_mem_start = v.ms; i_mem_cycles = v.mc;
        i_ex_load = v.ld; i_ex_rd = v.rd;
        i_id_rs_a = v.ra; i_id_rs_a_en = v.rae;
        i_id_rs_b = v.rb; i_id_rs_b_en = v.rbe;
        sb_q.push_back(v.exp);
        sample(name);
        tick();
        quiet();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t  vecs[12];
        string names[12];
        exp_t  none_e, br_e, lu_e, wait_e;

        none_e = mk_exp(4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0);
        br_e   = mk_exp(4'b0000, 4'b0011, 2'b01, 1'b1, 1'b0);
        lu_e   = mk_exp(4'b0001, 4'b0010, 2'b00, 1'b0, 1'b0);
        wait_e = mk_exp(4'b0111, 4'b1000, 2'b00, 1'b0, 1'b1);

        //             ir        apsr    ms    mc    ld    rd    ra    rae   rb    rbe
        vecs[0]  = mkv(16'hD012, 4'b0100, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, br_e);
        vecs[1]  = mkv(16'hD012, 4'b0000, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, none_e);
        vecs[2]  = mkv(16'hE005, 4'b0000, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, br_e);
        vecs[3]  = mkv(16'hDF10, 4'b1111, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, none_e);
        vecs[4]  = mkv(16'hDE00, 4'b1111, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, none_e);
        vecs[5]  = mkv(16'hD1F0, 4'b0000, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, br_e);
        vecs[6]  = mkv(16'h1C00, 4'b0000, 1'b0, 4'd0, 1'b1, 4'd3, 4'd3, 1'b1, 4'd0, 1'b0, lu_e);
        vecs[7]  = mkv(16'h1C00, 4'b0000, 1'b0, 4'd0, 1'b1, 4'd3, 4'd3, 1'b0, 4'd0, 1'b0, none_e);
        vecs[8]  = mkv(16'h1C00, 4'b0000, 1'b0, 4'd0, 1'b1, 4'd5, 4'd3, 1'b1, 4'd5, 1'b1, lu_e);
        vecs[9]  = mkv(16'h1C00, 4'b0000, 1'b0, 4'd0, 1'b0, 4'd3, 4'd3, 1'b1, 4'd0, 1'b0, none_e);
        vecs[10] = mkv(16'hD012, 4'b0100, 1'b0, 4'd0, 1'b1, 4'd3, 4'd3, 1'b1, 4'd0, 1'b0, br_e);
        vecs[11] = mkv(16'h1C00, 4'b0000, 1'b1, 4'd1, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, none_e);
        names = '{"beq_z1", "beq_z0", "b_uncond", "cond_1111", "cond_1110", "bne_z0",
                  "lu_rs_a", "lu_rs_a_off", "lu_rs_b", "lu_no_load", "lu_vs_branch", "mem_single"};

        // Reset state
        rst = 1'b1;
        quiet();
        repeat (2) @(posedge clk);
        #1;
        sb_q.push_back(none_e);
        compare("reset_outputs");
        check_ir_ex("reset_ir_ex");
        rst = 1'b0;
        tick();

        // Table vectors
        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i], names[i]);
        end

        // Condition sweep against the reference model
        for (int c = 0; c < 16; c++) begin
            for (int a = 0; a < 16; a++) begin
                logic [15:0] ir;
                logic [3:0]  ap;
                if (c == 14) ir = {5'b11100, 3'(a), 8'h21};
                else         ir = {4'hD, 4'(c), 8'h5A};
                ap = 4'(a);
                run_vec(mkv(ir, ap, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0,
                            ref_taken(ir, ap) ? br_e : none_e),
                        $sformatf("sweep_ir%h_apsr%b", ir, ap));
            end
        end

        // Four-cycle access: three wait cycles; starts during the wait are ignored
        quiet();
        i_ir_id = NOP;
        tick();
        i_mem_start = 1'b1; i_mem_cycles = 4'd4;
        sb_q.push_back(none_e);
        sample("mem4_start");
        tick();
        for (int k = 0; k < 3; k++) begin
            i_mem_start = (k < 2);
            sb_q.push_back(wait_e);
            sample($sformatf("mem4_wait%0d", k));
            tick();
        end
        i_mem_start = 1'b0;
        sb_q.push_back(none_e);
        sample("mem4_done");
        tick();
        sb_q.push_back(none_e);
        sample("mem4_idle");
        tick();

        // Single-cycle and zero-cycle accesses never stall
        i_mem_start = 1'b1; i_mem_cycles = 4'd1;
        sb_q.push_back(none_e);
        sample("mem1_start");
        tick();
        i_mem_cycles = 4'd0;
        sb_q.push_back(none_e);
        sample("mem0_start");
        tick();
        i_mem_start = 1'b0;
        sb_q.push_back(none_e);
        sample("mem01_after");
        tick();

        // Taken branch held in EX during a wait resolves once, afterwards
        quiet();
        i_ir_id = NOP;
        tick();
        i_ir_id = 16'hD012; i_mem_start = 1'b1; i_mem_cycles = 4'd3;
        sb_q.push_back(none_e);
        sample("brwait_load");
        tick();
        i_ir_id = 16'h0000; i_mem_start = 1'b0; i_apsr = 4'b0100;
        for (int k = 0; k < 2; k++) begin
            sb_q.push_back(wait_e);
            sample($sformatf("brwait_hold%0d", k));
            tick();
        end
        sb_q.push_back(br_e);
        sample("brwait_taken");
        tick();
        sb_q.push_back(none_e);
        sample("brwait_once");
        tick();

        // Asynchronous reset in the middle of a wait (count at 2)
        quiet();
        i_ir_id = NOP;
        tick();
        i_mem_start = 1'b1; i_mem_cycles = 4'd4;
        tick();
        i_mem_start = 1'b0;
        tick();
        sb_q.push_back(wait_e);
        compare("rst_pre_wait");
        #1 rst = 1'b1;
        #1;
        sb_q.push_back(none_e);
        compare("rst_async");
        tick();
        rst = 1'b0;
        i_apsr = 4'hF;
        check_ir_ex("rst_ir_ex");
        sb_q.push_back(none_e);
        sample("rst_after");
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
